cla_byte_serial_ctrl: RTL

Sequencer that time-shares one external 8-bit carry-lookahead adder slice to perform NBYTES-wide add/subtract operations, one byte per clock, LSB first. It accepts operands on a valid/ready input handshake and drives the shared slice's operand and carry-in pins. Each cycle it captures the slice's sum and carry-out, then presents the assembled result, carry and signed overflow on a valid/ready output handshake. It sits between the operand source (register file / test harness) and the 8-bit CLA datapath.

---
 rtl/cla_byte_serial_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cla_byte_serial_ctrl.sv
// Byte-serial add/subtract sequencer: drives one shared 8-bit CLA slice,
// one byte per clock LSB first, with valid/ready handshakes on both sides.
module cla_byte_serial_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  sub,
  input  logic                  carry_in,
  output logic [7:0]            cla_a,
  output logic [7:0]            cla_b,
  output logic                  cla_cin,
  input  logic [7:0]            cla_sum,
  input  logic                  cla_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [NBYTES-1:0][7:0]  a_q, a_d;
  logic [NBYTES-1:0][7:0]  b_q, b_d;
  logic [NBYTES-1:0][7:0]  res_q, res_d;
  logic                    c_q, c_d;
  logic                    co_q, co_d;
  logic                    ov_q, ov_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state logic and CLA slice drive
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    co_d    = co_q;
    ov_d    = ov_q;
    cla_a   = 8'd0;
    cla_b   = 8'd0;
    cla_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + ~borrow, so the carry-in flips with sub
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          c_d     = carry_in ^ sub;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cla_a        = a_q[idx_q];
        cla_b        = b_q[idx_q];
        cla_cin      = c_q;
        res_d[idx_q] = cla_sum;
        c_d          = cla_cout;
        if (idx_q == LAST_IDX) begin
          co_d    = cla_cout;
          ov_d    = (a_q[idx_q][7] == b_q[idx_q][7]) && (cla_sum[7] != a_q[idx_q][7]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;

endmodule
